sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter OUTSTANDING, 2, max in-flight transactions on master port (1..4).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 inst_req  in  1  instruction read request; held until inst_addr_ok.
REQ-005 inst_size  in  2  instruction size (0=byte, 1=half, 2=word).
REQ-006 inst_addr  in  32  instruction address.
REQ-007 inst_rdata  out  32  read data, valid with inst_data_ok.
REQ-008 inst_addr_ok  out  1  instruction request accepted this cycle.
REQ-009 inst_data_ok  out  1  instruction read data returned this cycle.
REQ-010 data_req  in  1  data request; held until data_raddr_ok/data_waddr_ok.
REQ-011 data_wr  in  1  1=write, 0=read.
REQ-012 data_size  in  2  data size.
REQ-013 data_strb  in  4  byte write strobes.
REQ-014 data_addr  in  32  data address.
REQ-015 data_wdata  in  32  write data.
REQ-016 data_rdata  out  32  read data, valid with data_rdata_ok.
REQ-017 data_raddr_ok  out  1  data read request accepted.
REQ-018 data_waddr_ok  out  1  data write request accepted.
REQ-019 data_rdata_ok  out  1  data read response.
REQ-020 data_wdata_ok  out  1  data write completion.
REQ-021 m_req  out  1  request to shared downstream sram-like slave.
REQ-022 m_wr  out  1  downstream write flag.
REQ-023 m_size  out  2  downstream size.
REQ-024 m_strb  out  4  downstream strobes; 4'b0000 for instruction reads.
REQ-025 m_addr  out  32  downstream address.
REQ-026 m_wdata  out  32  downstream write data; 0 for instruction reads.
REQ-027 m_rdata  in  32  downstream read data.
REQ-028 m_addr_ok  in  1  downstream accepted m_req this cycle.
REQ-029 m_data_ok  in  1  downstream response this cycle; responses strictly in issue order.

Function
REQ-030 Arbitration: round-robin on last accepted source; with both requesting and no lock, the source not granted last wins; after reset data wins first.
REQ-031 Grant lock: once m_req is asserted for a source, m_* fields stay on that source until m_addr_ok; no regrant mid-handshake.
REQ-032 m_req = granted source req AND inflight count < OUTSTANDING; combinational from lock register, count and inputs.
REQ-033 inst_addr_ok = m_addr_ok & m_req & grant=INST; data_raddr_ok/data_waddr_ok = m_addr_ok & m_req & grant=DATA & !data_wr/data_wr.
REQ-034 Each accepted transaction pushes {src, wr} into an in-order FIFO of depth OUTSTANDING, same cycle as m_addr_ok.
REQ-035 m_data_ok pops FIFO head and routes: INST -> inst_data_ok; DATA read -> data_rdata_ok; DATA write -> data_wdata_ok; exactly one pulses.
REQ-036 inst_rdata and data_rdata both driven from m_rdata unregistered; zero-latency passthrough of ok pulses.
REQ-037 Simultaneous push and pop: count unchanged, pointers both advance.
REQ-038 Full (count == OUTSTANDING): m_req low, no addr_ok to any requester; pop in the same cycle does not enable issue until next cycle.
REQ-039 m_data_ok while FIFO empty: ignored, no ok output, count stays 0.
REQ-040 Pointers wrap modulo OUTSTANDING; count width clog2(OUTSTANDING+1).

Reset
REQ-041 While resetn low: FIFO empty, count 0, grant lock clear, last-grant = INST; all ok outputs and m_req 0.
REQ-042 Reset mid-operation discards in-flight transactions; later m_data_ok for them is ignored per REQ-039.

Structure
REQ-043 Shared package: SRC_INST=0/SRC_DATA=1, size encodings SIZE_B/H/W.
REQ-044 FIFO is sub-module sram_like_txn_fifo (depth param, 2-bit entry, full/empty/count outputs).

Verification
REQ-045 Inst-only read 0xBFC00000, m_addr_ok next cycle, m_data_ok +2 with 0x3C080001 -> one inst_addr_ok, one inst_data_ok, inst_rdata=0x3C080001.
REQ-046 inst_req and data_req (read) same cycle after reset -> data granted first, inst second; responses routed in issue order.
REQ-047 m_addr_ok held low 3 cycles while inst_req arrives -> m_addr stays data_addr, grant unchanged until accept.
REQ-048 OUTSTANDING=2, three back-to-back requests, no m_data_ok -> third m_req held low until first m_data_ok, then issued.
REQ-049 Data write strb 4'b0011 size 1 -> m_strb=4'b0011, completion pulses data_wdata_ok only, never data_rdata_ok.
REQ-050 resetn pulsed low with 2 in flight, then spurious m_data_ok -> no ok outputs, count 0.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like two-source arbiter: source ids, size codes
// and the in-flight transaction record kept in the ordering FIFO.
package sram_like_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        src_e src;
        logic wr;
    } txn_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the instruction, data and downstream sram-like buses.
// slave is the arbiter's view; master is the surrounding CPU/memory view.
interface sram_like_arbiter_if;

    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_strb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_raddr_ok;
    logic        data_waddr_ok;
    logic        data_rdata_ok;
    logic        data_wdata_ok;

    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_strb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_addr_ok;
    logic        m_data_ok;

    modport slave (
        input  inst_req, inst_size, inst_addr,
        output inst_rdata, inst_addr_ok, inst_data_ok,
        input  data_req, data_wr, data_size, data_strb, data_addr, data_wdata,
        output data_rdata, data_raddr_ok, data_waddr_ok, data_rdata_ok, data_wdata_ok,
        output m_req, m_wr, m_size, m_strb, m_addr, m_wdata,
        input  m_rdata, m_addr_ok, m_data_ok
    );

    modport master (
        output inst_req, inst_size, inst_addr,
        input  inst_rdata, inst_addr_ok, inst_data_ok,
        output data_req, data_wr, data_size, data_strb, data_addr, data_wdata,
        input  data_rdata, data_raddr_ok, data_waddr_ok, data_rdata_ok, data_wdata_ok,
        input  m_req, m_wr, m_size, m_strb, m_addr, m_wdata,
        output m_rdata, m_addr_ok, m_data_ok
    );

endinterface

// File: rtl/sram_like_txn_fifo.sv
// In-order record of issued downstream transactions; the head tells the
// arbiter where the next downstream response belongs.
module sram_like_txn_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  txn_t                         push_entry,
    input  logic                         pop,
    output txn_t                         head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    txn_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Explicit wrap keeps non-power-of-two depths correct.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter sharing one sram-like slave between an instruction and
// a data requester, routing in-order responses back through a txn FIFO.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                resetn,
    sram_like_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    src_e             grant;
    src_e             last_grant;
    src_e             lock_src;
    logic             lock_valid;
    logic             src_req;
    logic             accept;
    logic             rsp_valid;
    txn_t             push_entry;
    txn_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // A pending handshake keeps its source; otherwise favour whoever lost last.
    always_comb begin
        grant = (last_grant == SRC_INST) ? SRC_DATA : SRC_INST;
        if (lock_valid) begin
            grant = lock_src;
        end else if (bus.inst_req && !bus.data_req) begin
            grant = SRC_INST;
        end else if (bus.data_req && !bus.inst_req) begin
            grant = SRC_DATA;
        end
    end

    assign src_req   = (grant == SRC_INST) ? bus.inst_req : bus.data_req;
    assign bus.m_req = resetn && src_req && (fifo_count < CNT_W'(OUTSTANDING));
    assign accept    = bus.m_req && bus.m_addr_ok;

    assign bus.m_wr    = (grant == SRC_DATA) && bus.data_wr;
    assign bus.m_size  = (grant == SRC_DATA) ? bus.data_size  : bus.inst_size;
    assign bus.m_addr  = (grant == SRC_DATA) ? bus.data_addr  : bus.inst_addr;
    assign bus.m_strb  = (grant == SRC_DATA) ? bus.data_strb  : 4'b0000;
    assign bus.m_wdata = (grant == SRC_DATA) ? bus.data_wdata : 32'h0000_0000;

    assign bus.inst_addr_ok  = accept && (grant == SRC_INST);
    assign bus.data_raddr_ok = accept && (grant == SRC_DATA) && !bus.data_wr;
    assign bus.data_waddr_ok = accept && (grant == SRC_DATA) && bus.data_wr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_src   <= SRC_INST;
            last_grant <= SRC_INST;
        end else if (accept) begin
            lock_valid <= 1'b0;
            last_grant <= grant;
        end else begin
            lock_valid <= bus.m_req;
            lock_src   <= grant;
        end
    end

    assign push_entry.src = grant;
    assign push_entry.wr  = bus.m_wr;

    sram_like_txn_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_txn_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept && !fifo_full),
        .push_entry (push_entry),
        .pop        (bus.m_data_ok),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Responses with nothing in flight (e.g. orphaned by reset) are dropped.
    assign rsp_valid = bus.m_data_ok && !fifo_empty;

    assign bus.inst_data_ok  = rsp_valid && (head.src == SRC_INST);
    assign bus.data_rdata_ok = rsp_valid && (head.src == SRC_DATA) && !head.wr;
    assign bus.data_wdata_ok = rsp_valid && (head.src == SRC_DATA) && head.wr;
    assign bus.inst_rdata    = bus.m_rdata;
    assign bus.data_rdata    = bus.m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: expected accepts/responses are queued
// by the stimulus and matched by an independent negedge monitor.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int OUTSTANDING = 2;
    localparam int K_INST = 0;
    localparam int K_DRD  = 1;
    localparam int K_DWR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          kind;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    logic [31:0] snap_m_req;
    logic [31:0] snap_m_addr;
    logic [31:0] snap_m_strb;
    logic [31:0] snap_m_wdata;
    logic [31:0] snap_aok;
    logic [31:0] snap_dok;

    sram_like_arbiter_if bus();

    sram_like_arbiter #(
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expAcc(input int kind, input logic [31:0] addr, input logic [3:0] strb,
                          input logic wr, input logic [1:0] size, input logic [31:0] wdata);
        acc_t a;
        a.kind = kind; a.addr = addr; a.strb = strb;
        a.wr = wr; a.size = size; a.wdata = wdata;
        acc_q.push_back(a);
    endtask

    task automatic expRsp(input int kind, input logic [31:0] rdata);
        rsp_t r;
        r.kind = kind; r.rdata = rdata;
        rsp_q.push_back(r);
    endtask

    // One downstream cycle: drive slave handshake, snapshot at negedge.
    task automatic applyStimulus(input logic aok, input logic dok, input logic [31:0] rdata);
        bus.m_addr_ok = aok;
        bus.m_data_ok = dok;
        bus.m_rdata   = rdata;
        @(negedge clk);
        snap_m_req   = 32'(bus.m_req);
        snap_m_addr  = bus.m_addr;
        snap_m_strb  = 32'(bus.m_strb);
        snap_m_wdata = bus.m_wdata;
        snap_aok     = 32'({bus.inst_addr_ok, bus.data_raddr_ok, bus.data_waddr_ok});
        snap_dok     = 32'({bus.inst_data_ok, bus.data_rdata_ok, bus.data_wdata_ok});
        @(posedge clk);
        #1;
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
    endtask

    task automatic resetTask();
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        resetn = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        acc_t a;
        rsp_t r;
        int   na;
        int   nr;
        int   kind;
        na = int'(bus.inst_addr_ok) + int'(bus.data_raddr_ok) + int'(bus.data_waddr_ok);
        nr = int'(bus.inst_data_ok) + int'(bus.data_rdata_ok) + int'(bus.data_wdata_ok);
        if (na != 0) begin
            checkOutput("accept_onehot", 32'(na), 32'd1);
            kind = bus.inst_addr_ok ? K_INST : (bus.data_raddr_ok ? K_DRD : K_DWR);
            if (acc_q.size() == 0) begin
                checkOutput("unexpected_accept", 32'(na), 32'd0);
            end else begin
                a = acc_q.pop_front();
                checkOutput("accept_kind", 32'(kind), 32'(a.kind));
                checkOutput("m_addr", bus.m_addr, a.addr);
                checkOutput("m_strb", 32'(bus.m_strb), 32'(a.strb));
                checkOutput("m_wr", 32'(bus.m_wr), 32'(a.wr));
                checkOutput("m_size", 32'(bus.m_size), 32'(a.size));
                checkOutput("m_wdata", bus.m_wdata, a.wdata);
            end
        end
        if (nr != 0) begin
            checkOutput("rsp_onehot", 32'(nr), 32'd1);
            kind = bus.inst_data_ok ? K_INST : (bus.data_rdata_ok ? K_DRD : K_DWR);
            if (rsp_q.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(nr), 32'd0);
            end else begin
                r = rsp_q.pop_front();
                checkOutput("rsp_kind", 32'(kind), 32'(r.kind));
                if (r.kind == K_INST) begin
                    checkOutput("inst_rdata", bus.inst_rdata, r.rdata);
                end else if (r.kind == K_DRD) begin
                    checkOutput("data_rdata", bus.data_rdata, r.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("[TB] FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        resetn         = 1'b0;
        bus.inst_req   = 1'b0;
        bus.inst_size  = SIZE_W;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = SIZE_W;
        bus.data_strb  = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.m_rdata    = 32'h0;
        bus.m_addr_ok  = 1'b0;
        bus.m_data_ok  = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset holds everything quiet");
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h1234_5678);
        checkOutput("reset_m_req", snap_m_req, 32'd0);
        checkOutput("reset_addr_ok", snap_aok, 32'd0);
        checkOutput("reset_data_ok", snap_dok, 32'd0);
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        resetn = 1'b1;

        $display("[TB] single instruction fetch");
        bus.inst_addr  = 32'hBFC0_0000;
        bus.data_wdata = 32'hFFFF_FFFF;
        bus.data_strb  = 4'hF;
        expAcc(K_INST, 32'hBFC0_0000, 4'h0, 1'b0, SIZE_W, 32'h0);
        expRsp(K_INST, 32'h3C08_0001);
        bus.inst_req = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t1_m_req", snap_m_req, 32'd1);
        checkOutput("t1_m_addr", snap_m_addr, 32'hBFC0_0000);
        checkOutput("t1_m_strb", snap_m_strb, 32'd0);
        checkOutput("t1_m_wdata", snap_m_wdata, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t1_inst_addr_ok", snap_aok, 32'b100);
        bus.inst_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h3C08_0001);
        checkOutput("t1_inst_data_ok", snap_dok, 32'b100);
        bus.data_wdata = 32'h0;
        bus.data_strb  = 4'h0;

        $display("[TB] simultaneous requests after reset");
        resetTask();
        bus.inst_addr = 32'hBFC0_0010;
        bus.data_addr = 32'h8000_1000;
        expAcc(K_DRD, 32'h8000_1000, 4'h0, 1'b0, SIZE_W, 32'h0);
        expAcc(K_INST, 32'hBFC0_0010, 4'h0, 1'b0, SIZE_W, 32'h0);
        expRsp(K_DRD, 32'h1111_1111);
        expRsp(K_INST, 32'h2222_2222);
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t2_data_first", snap_aok, 32'b010);
        bus.data_req = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t2_inst_second", snap_aok, 32'b100);
        bus.inst_req = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h1111_1111);
        checkOutput("t2_rsp_data", snap_dok, 32'b010);
        applyStimulus(1'b0, 1'b1, 32'h2222_2222);
        checkOutput("t2_rsp_inst", snap_dok, 32'b100);

        $display("[TB] halfword write with partial strobes");
        bus.data_wr    = 1'b1;
        bus.data_addr  = 32'h8000_3000;
        bus.data_size  = SIZE_H;
        bus.data_strb  = 4'b0011;
        bus.data_wdata = 32'hAABB_CCDD;
        expAcc(K_DWR, 32'h8000_3000, 4'b0011, 1'b1, SIZE_H, 32'hAABB_CCDD);
        expRsp(K_DWR, 32'h0);
        bus.data_req = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t5_m_strb", snap_m_strb, 32'b0011);
        checkOutput("t5_waddr_ok", snap_aok, 32'b001);
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = SIZE_W;
        bus.data_strb  = 4'h0;
        bus.data_wdata = 32'h0;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("t5_wdata_ok_only", snap_dok, 32'b001);

        $display("[TB] stalled handshake keeps its grant");
        bus.data_addr = 32'h8000_2000;
        expAcc(K_DRD, 32'h8000_2000, 4'h0, 1'b0, SIZE_W, 32'h0);
        expAcc(K_INST, 32'hBFC0_0020, 4'h0, 1'b0, SIZE_W, 32'h0);
        expRsp(K_DRD, 32'h3333_3333);
        expRsp(K_INST, 32'h4444_4444);
        bus.data_req = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t3_m_req", snap_m_req, 32'd1);
        bus.inst_addr = 32'hBFC0_0020;
        bus.inst_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("t3_hold_addr", snap_m_addr, 32'h8000_2000);
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t3_data_accept", snap_aok, 32'b010);
        bus.data_req = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t3_inst_accept", snap_aok, 32'b100);
        bus.inst_req = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h3333_3333);
        applyStimulus(1'b0, 1'b1, 32'h4444_4444);

        $display("[TB] outstanding limit");
        bus.inst_addr = 32'hBFC0_0030;
        bus.data_addr = 32'h8000_4000;
        expAcc(K_DRD, 32'h8000_4000, 4'h0, 1'b0, SIZE_W, 32'h0);
        expAcc(K_INST, 32'hBFC0_0030, 4'h0, 1'b0, SIZE_W, 32'h0);
        expAcc(K_DRD, 32'h8000_4004, 4'h0, 1'b0, SIZE_W, 32'h0);
        expRsp(K_DRD, 32'h5555_5555);
        expRsp(K_INST, 32'h6666_6666);
        expRsp(K_DRD, 32'h7777_7777);
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4_first", snap_aok, 32'b010);
        bus.data_addr = 32'h8000_4004;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4_second", snap_aok, 32'b100);
        bus.inst_req = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4_full_m_req", snap_m_req, 32'd0);
        checkOutput("t4_full_addr_ok", snap_aok, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h5555_5555);
        checkOutput("t4_pop_same_cycle", snap_m_req, 32'd0);
        checkOutput("t4_pop_rsp", snap_dok, 32'b010);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4_third", snap_aok, 32'b010);
        bus.data_req = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h6666_6666);
        applyStimulus(1'b0, 1'b1, 32'h7777_7777);

        $display("[TB] reset with transactions in flight");
        bus.inst_addr = 32'hBFC0_0040;
        bus.data_addr = 32'h8000_5000;
        expAcc(K_INST, 32'hBFC0_0040, 4'h0, 1'b0, SIZE_W, 32'h0);
        expAcc(K_DRD, 32'h8000_5000, 4'h0, 1'b0, SIZE_W, 32'h0);
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t6_inst_first", snap_aok, 32'b100);
        bus.inst_req = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t6_data_second", snap_aok, 32'b010);
        bus.data_req = 1'b0;
        resetTask();
        applyStimulus(1'b0, 1'b1, 32'h9999_9999);
        checkOutput("t6_spurious_1", snap_dok, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h9999_999A);
        checkOutput("t6_spurious_2", snap_dok, 32'd0);
        bus.inst_addr = 32'hBFC0_0050;
        expAcc(K_INST, 32'hBFC0_0050, 4'h0, 1'b0, SIZE_W, 32'h0);
        expRsp(K_INST, 32'h8888_8888);
        bus.inst_req = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t6_count_cleared", snap_aok, 32'b100);
        bus.inst_req = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h8888_8888);
        checkOutput("t6_post_reset_rsp", snap_dok, 32'b100);

        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("acc_q_drained", 32'(acc_q.size()), 32'd0);
        checkOutput("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
